id_issue_ctrl: RTL

//  Issue/hazard controller for the ID stage of the 5-stage RV32 pipeline. It keeps a shadow

---
 rtl/id_issue_ctrl_pkg.sv | 25 ++
 rtl/id_hazard_detect.sv | 32 +++
 rtl/id_issue_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared types for the ID-stage issue controller: FSM states, shadow scoreboard entry,
// and the destination-match helper used by the hazard detector.
package id_issue_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
  } shadow_t;

  // x0 is hardwired to zero, so a write to it can never create a dependency.
  function automatic logic entry_match(shadow_t e, logic [REG_W-1:0] rs);
    return e.v && e.rw && (e.rd != '0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational RAW hazard detection against the EX/MEM/WB shadow entries.
module id_hazard_detect
  import id_issue_ctrl_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter bit WB_BYPASS  = 1'b1
) (
  input  shadow_t          i_ex,
  input  shadow_t          i_mem,
  input  shadow_t          i_wb,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  output logic             o_hz
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = (i_use_rs1 && entry_match(i_ex,  i_rs1)) || (i_use_rs2 && entry_match(i_ex,  i_rs2));
  assign w_mem_hit = (i_use_rs1 && entry_match(i_mem, i_rs1)) || (i_use_rs2 && entry_match(i_mem, i_rs2));
  assign w_wb_hit  = (i_use_rs1 && entry_match(i_wb,  i_rs1)) || (i_use_rs2 && entry_match(i_wb,  i_rs2));

  // With forwarding only a load in EX cannot be bypassed in time.
  always_comb begin
    if (FORWARDING) o_hz = w_ex_hit && i_ex.mr;
    else            o_hz = w_ex_hit || w_mem_hit || (w_wb_hit && !WB_BYPASS);
  end

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue/hazard controller: shadow scoreboard, RAW stall, branch squash,
// halt/drain handshake and saturating stall/flush counters.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter bit FORWARDING = 1'b1,
  parameter bit WB_BYPASS  = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_ID,
  input  logic [REG_W-1:0] RS1_ID,
  input  logic [REG_W-1:0] RS2_ID,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [REG_W-1:0] RD_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             taken_EX,
  input  logic             halt_req,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e     r_state;
  state_e     w_state_nxt;
  shadow_t    r_ex, r_mem, r_wb;
  shadow_t    w_ex_nxt;
  logic       w_hz, w_stall, w_issue;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  id_hazard_detect #(
    .FORWARDING (FORWARDING),
    .WB_BYPASS  (WB_BYPASS)
  ) u_hazard (
    .i_ex      (r_ex),
    .i_mem     (r_mem),
    .i_wb      (r_wb),
    .i_rs1     (RS1_ID),
    .i_rs2     (RS2_ID),
    .i_use_rs1 (use_rs1),
    .i_use_rs2 (use_rs2),
    .o_hz      (w_hz)
  );

  assign w_stall = valid_ID && w_hz && !taken_EX;
  assign w_issue = (r_state == ST_RUN) && valid_ID && !w_stall && !taken_EX;

  always_comb begin
    w_ex_nxt = '0;
    if (w_issue) w_ex_nxt = '{v: 1'b1, rd: RD_ID, rw: RegWrite_ID, mr: MemRead_ID};
  end

  // NOTE: reset is synchronous, so it sits inside the clocked block and every register
  // (shadow included) is cleared explicitly; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ex    <= w_ex_nxt;
      r_mem   <= r_ex;
      r_wb    <= r_mem;
    end
  end

  // Drain completes once the shadow about to be loaded (ex_nxt, ex, mem) is empty.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:    if (halt_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!halt_req)                                  w_state_nxt = ST_RUN;
        else if (!(w_ex_nxt.v || r_ex.v || r_mem.v))    w_state_nxt = ST_HALTED;
      end
      ST_HALTED: if (!halt_req) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: every output gets a default first so this block cannot infer a latch.
  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    halt_ack     = 1'b0;
    if (reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else begin
      halt_ack = (r_state == ST_HALTED);
      if (taken_EX) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Bubble = 1'b1;
      end else if (w_stall || (r_state != ST_RUN)) begin
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (taken_EX && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
